icache_l1_nway: RTL and testbench

Parametrised successor to the L1 instruction cache:
- S-set, E-way, B-byte-line instruction cache with a configurable L2 refill width.
- True-LRU replacement with invalid-way priority.
- Global invalidate (flush).
- Branch-aware refill permission.

It sits in the Fetch stage between the PC register and the L2 refill path. It returns `instr_f_o` combinationally on a hit and streams `FILL_W`-bit beats from L2 on a miss.

---
 rtl/icache_l1_nway.sv | 205 ++++++++++++++++++++
 tb/tb_icache_l1_nway.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_l1_nway.sv
// icache_l1_nway: S-set, E-way, B-byte-line L1 instruction cache.
// Lookup is combinational, replacement is true-LRU with invalid-way priority,
// and misses refill from L2 in FILL_W-bit beats, lowest beat first.
// Optional feature macro: ICACHE_PERF_CNT_EN adds the hit/miss counter ports.
module icache_l1_nway #(
  parameter int S      = 32,
  parameter int E      = 4,
  parameter int B      = 64,
  parameter int FILL_W = 64
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [31:0]       pc_f_i,
  input  logic [1:0]        pc_src_reg_i,
  input  logic [1:0]        branch_op_e_i,
  input  logic              l2_repl_ready_i,
  input  logic [FILL_W-1:0] rep_word_i,
  input  logic              flush_i,
  output logic [31:0]       instr_f_o,
  output logic              instr_hit_f_o,
  output logic              ic_repl_permit_o
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int OFF_W      = $clog2(B);
  localparam int SET_W      = $clog2(S);
  localparam int WAY_W      = $clog2(E);
  localparam int TAG_W      = 32 - SET_W - OFF_W;
  localparam int WORD_W     = OFF_W - 2;
  localparam int LINE_W     = B * 8;
  localparam int LINE_IDX_W = $clog2(LINE_W);
  localparam int BEATS      = LINE_W / FILL_W;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam bit SINGLE     = (BEATS == 1);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [WAY_W-1:0] OLDEST    = WAY_W'(E - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t state;

  logic [LINE_W-1:0] data_mem [S][E];
  logic [TAG_W-1:0]  tag_mem  [S][E];
  logic [E-1:0]      valid    [S];
  logic [WAY_W-1:0]  age      [S][E];

  logic [SET_W-1:0] fill_set;
  logic [TAG_W-1:0] fill_tag;
  logic [WAY_W-1:0] fill_way;
  logic [CNT_W-1:0] beat_cnt;

  logic [SET_W-1:0]  cur_set;
  logic [TAG_W-1:0]  cur_tag;
  logic [WORD_W-1:0] cur_word;
  logic              unused_pc_bits;

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic             do_start;
  logic             do_beat;
  logic             fill_done;

  logic [SET_W-1:0] wr_set;
  logic [WAY_W-1:0] wr_way;
  logic [TAG_W-1:0] wr_tag;
  logic [CNT_W-1:0] wr_beat;

  logic             lru_en;
  logic [SET_W-1:0] lru_set;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] new_age [E];

  assign cur_set        = pc_f_i[SET_W+OFF_W-1:OFF_W];
  assign cur_tag        = pc_f_i[31:SET_W+OFF_W];
  assign cur_word       = pc_f_i[OFF_W-1:2];
  assign unused_pc_bits = ^pc_f_i[1:0];

  // Compare every way of the addressed set and return the hit word, zero on a miss.
  always_comb begin
    logic any_match;
    any_match = 1'b0;
    hit_way   = '0;
    for (int w = 0; w < E; w++) begin
      if (valid[cur_set][w] && (tag_mem[cur_set][w] == cur_tag)) begin
        any_match = 1'b1;
        hit_way   = WAY_W'(w);
      end
    end
    hit           = any_match && (state == IDLE) && !reset_i;
    instr_hit_f_o = hit;
    instr_f_o     = hit ? data_mem[cur_set][hit_way][LINE_IDX_W'(int'(cur_word) * 32) +: 32] : 32'h0;
  end

  // Pick the victim: lowest-index invalid way, otherwise the oldest way.
  always_comb begin
    victim = '0;
    for (int w = 0; w < E; w++) begin
      if (age[cur_set][w] == OLDEST) victim = WAY_W'(w);
    end
    for (int w = E - 1; w >= 0; w--) begin
      if (!valid[cur_set][w]) victim = WAY_W'(w);
    end
  end

  // Refill permission and the per-cycle fill events; a redirect or unresolved branch holds off the start.
  always_comb begin
    ic_repl_permit_o = (reset_i || (state == IDLE)) && !hit &&
                       (pc_src_reg_i == 2'b00) && (branch_op_e_i == 2'b00);
    do_start  = (state == IDLE) && ic_repl_permit_o && l2_repl_ready_i && !flush_i && !reset_i;
    do_beat   = (state == FILL) && l2_repl_ready_i && !flush_i && !reset_i;
    fill_done = (do_start && SINGLE) || (do_beat && (beat_cnt == LAST_BEAT));
    wr_set    = (state == FILL) ? fill_set : cur_set;
    wr_way    = (state == FILL) ? fill_way : victim;
    wr_tag    = (state == FILL) ? fill_tag : cur_tag;
    wr_beat   = do_start ? '0 : beat_cnt;
  end

  // Next ages for the touched set: accessed way becomes youngest, younger ways age by one.
  always_comb begin
    logic [WAY_W-1:0] old_age;
    lru_en  = hit || fill_done;
    lru_set = (state == FILL) ? fill_set : cur_set;
    lru_way = hit ? hit_way : wr_way;
    old_age = age[lru_set][lru_way];
    for (int j = 0; j < E; j++) begin
      new_age[j] = age[lru_set][j];
      if (WAY_W'(j) == lru_way) begin
        new_age[j] = '0;
      end else if (age[lru_set][j] < old_age) begin
        new_age[j] = age[lru_set][j] + 1'b1;
      end
    end
  end

  // Line data and tag storage; written beat by beat and tagged on the final beat.
  always_ff @(posedge clk_i) begin
    if (do_start || do_beat) begin
      data_mem[wr_set][wr_way][LINE_IDX_W'(int'(wr_beat) * FILL_W) +: FILL_W] <= rep_word_i;
    end
    if (fill_done) begin
      tag_mem[wr_set][wr_way] <= wr_tag;
    end
  end

  // Refill FSM with valid bits and LRU ages; flush aborts a fill and invalidates everything.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      beat_cnt <= '0;
      fill_set <= '0;
      fill_tag <= '0;
      fill_way <= '0;
      for (int s = 0; s < S; s++) begin
        valid[s] <= '0;
        for (int w = 0; w < E; w++) age[s][w] <= WAY_W'(w);
      end
    end else begin
      if (lru_en) begin
        for (int j = 0; j < E; j++) age[lru_set][j] <= new_age[j];
      end
      if (flush_i) begin
        state <= IDLE;
        for (int s = 0; s < S; s++) valid[s] <= '0;
      end else if (do_start) begin
        fill_set <= cur_set;
        fill_tag <= cur_tag;
        fill_way <= victim;
        beat_cnt <= CNT_W'(1);
        if (SINGLE) begin
          valid[cur_set][victim] <= 1'b1;
          state                  <= IDLE;
        end else begin
          valid[cur_set][victim] <= 1'b0;
          state                  <= FILL;
        end
      end else if (do_beat) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (beat_cnt == LAST_BEAT) begin
          valid[fill_set][fill_way] <= 1'b1;
          state                     <= IDLE;
        end
      end
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Performance counters: hit cycles and fill starts, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit) hit_cnt_o <= hit_cnt_o + 32'd1;
      if (do_start) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_l1_nway.sv
// tb_icache_l1_nway: checks icache_l1_nway against a timestamp-LRU reference model,
// plus directed sequences for replacement, branch hold-off, stalls and flush.
module tb_icache_l1_nway;
  localparam int S = 32, E = 4, BEATS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, ready, flush, ready128;
  logic [31:0]  pc;
  logic [1:0]   pc_src, br_op;
  logic [63:0]  rep;
  logic [127:0] rep128;
  logic [31:0]  instr, instr128;
  logic         hit, permit, hit128, permit128;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt, hit_cnt128, miss_cnt128;
`endif

  int total = 0;
  int bad = 0;
  logic        s_hit, s_permit, s_hit128, s_permit128;
  logic [31:0] s_instr, s_instr128, s_hc, s_mc;

  icache_l1_nway #(.S(32), .E(4), .B(64), .FILL_W(64)) u_dut (
    .clk_i(clk), .reset_i(reset), .pc_f_i(pc), .pc_src_reg_i(pc_src), .branch_op_e_i(br_op),
    .l2_repl_ready_i(ready), .rep_word_i(rep), .flush_i(flush),
    .instr_f_o(instr), .instr_hit_f_o(hit), .ic_repl_permit_o(permit)
`ifdef ICACHE_PERF_CNT_EN
    , .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
`endif
  );

  icache_l1_nway #(.S(32), .E(4), .B(64), .FILL_W(128)) u_dut128 (
    .clk_i(clk), .reset_i(reset), .pc_f_i(pc), .pc_src_reg_i(pc_src), .branch_op_e_i(br_op),
    .l2_repl_ready_i(ready128), .rep_word_i(rep128), .flush_i(flush),
    .instr_f_o(instr128), .instr_hit_f_o(hit128), .ic_repl_permit_o(permit128)
`ifdef ICACHE_PERF_CNT_EN
    , .hit_cnt_o(hit_cnt128), .miss_cnt_o(miss_cnt128)
`endif
  );

  // Reference model: per-line valid/tag/words, LRU as last-use timestamps.
  bit          mvalid [S][E];
  int unsigned mtag   [S][E];
  logic [31:0] mdata  [S][E][16];
  longint      mstamp [S][E];
  longint      mclock;
  bit          mfill;
  int          mfset, mfway, mfgot;
  int unsigned mftag;
  int unsigned mhits, mmisses;

  typedef struct {
    logic [1:0] src;
    logic [1:0] br;
    logic       exp_permit;
  } vec_t;

  function automatic logic [31:0] lw(int seed, int i);
    return {16'(seed), 8'h5A, 8'(i)};
  endfunction

  function automatic logic [63:0] beat64(int seed, int k);
    return {lw(seed, 2*k+1), lw(seed, 2*k)};
  endfunction

  function automatic logic [31:0] addr(int tag, int set);
    return (32'(tag) << 11) | (32'(set) << 6);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < S; s++)
      for (int w = 0; w < E; w++) begin
        mvalid[s][w] = 0;
        mstamp[s][w] = -w;
      end
    mclock = 0; mfill = 0; mhits = 0; mmisses = 0;
  endtask

  task automatic model_lookup(input logic [31:0] a, output bit h, output int way);
    h = 0; way = 0;
    if (!mfill)
      for (int w = 0; w < E; w++)
        if (mvalid[a[10:6]][w] && mtag[a[10:6]][w] == 32'(a[31:11])) begin h = 1; way = w; end
  endtask

  function automatic int model_victim(int s);
    int v = 0;
    for (int w = 1; w < E; w++) if (mstamp[s][w] < mstamp[s][v]) v = w;
    for (int w = E - 1; w >= 0; w--) if (!mvalid[s][w]) v = w;
    return v;
  endfunction

  task automatic model_step(input logic [31:0] a, input logic [1:0] s, input logic [1:0] b,
                            input logic r, input logic [63:0] d, input logic f, input logic rs,
                            input bit mh, input int mw);
    int st;
    st = int'(a[10:6]);
    if (rs) model_reset();
    else begin
      if (mh) begin mclock++; mstamp[st][mw] = mclock; mhits++; end
      if (f) begin
        for (int i = 0; i < S; i++) for (int w = 0; w < E; w++) mvalid[i][w] = 0;
        mfill = 0;
      end else if (!mfill) begin
        if (!mh && s == 0 && b == 0 && r) begin
          mfway = model_victim(st); mfset = st; mftag = 32'(a[31:11]);
          mvalid[st][mfway] = 0;
          mdata[st][mfway][0] = d[31:0]; mdata[st][mfway][1] = d[63:32];
          mfgot = 1; mfill = 1; mmisses++;
        end
      end else if (r) begin
        mdata[mfset][mfway][2*mfgot] = d[31:0]; mdata[mfset][mfway][2*mfgot+1] = d[63:32];
        mfgot++;
        if (mfgot == BEATS) begin
          mtag[mfset][mfway] = mftag; mvalid[mfset][mfway] = 1;
          mclock++; mstamp[mfset][mfway] = mclock; mfill = 0;
        end
      end
    end
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare against the model mid-cycle, advance the model at the edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [1:0] s, input logic [1:0] b,
                               input logic r, input logic [63:0] d, input logic f, input logic rs);
    bit mh; int mw; logic [31:0] ei; logic ep;
    pc = a; pc_src = s; br_op = b; ready = r; rep = d; flush = f; reset = rs;
    #2;
    model_lookup(a, mh, mw);
    if (rs) mh = 0;
    ei = mh ? mdata[a[10:6]][mw][a[5:2]] : 32'h0;
    ep = (rs || !mfill) && !mh && s == 2'b00 && b == 2'b00;
    s_hit = hit; s_instr = instr; s_permit = permit;
    s_hit128 = hit128; s_instr128 = instr128; s_permit128 = permit128;
    checkOutput("model_hit", s_hit, mh);
    checkOutput("model_instr", s_instr, ei);
    checkOutput("model_permit", s_permit, ep);
`ifdef ICACHE_PERF_CNT_EN
    s_hc = hit_cnt; s_mc = miss_cnt;
    checkOutput("model_hit_cnt", s_hc, mhits);
    checkOutput("model_miss_cnt", s_mc, mmisses);
`endif
    @(posedge clk);
    model_step(a, s, b, r, d, f, rs, mh, mw);
    @(negedge clk);
  endtask

  task automatic fillLine(input logic [31:0] a, input int seed, input int flush_at);
    for (int k = 0; k < BEATS; k++) begin
      if (flush_at < 0 || k <= flush_at)
        applyStimulus(a, 2'b00, 2'b00, 1'b1, beat64(seed, k), (k == flush_at), 1'b0);
    end
  endtask

  task automatic readLine(input logic [31:0] a, input int seed);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(a | (32'(i) << 2), 2'b00, 2'b00, 1'b0, 64'h0, 1'b0, 1'b0);
      checkOutput("read_hit", s_hit, 1);
      checkOutput("read_word", s_instr, lw(seed, i));
    end
  endtask

  task automatic probe(input logic [31:0] a);
    applyStimulus(a, 2'b00, 2'b00, 1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  initial begin
    vec_t vt[6];
    logic [31:0] a;
    vt[0] = '{2'b00, 2'b00, 1'b1};
    vt[1] = '{2'b01, 2'b00, 1'b0};
    vt[2] = '{2'b00, 2'b10, 1'b0};
    vt[3] = '{2'b11, 2'b11, 1'b0};
    vt[4] = '{2'b10, 2'b00, 1'b0};
    vt[5] = '{2'b00, 2'b01, 1'b0};
    reset = 1'b1; flush = 1'b0; ready = 1'b0; ready128 = 1'b0; rep128 = '0;
    pc = '0; pc_src = '0; br_op = '0; rep = '0;
    model_reset();
    @(negedge clk);

    // Reset state, reset together with flush
    applyStimulus(addr(1, 1), 2'b00, 2'b00, 1'b0, 64'h0, 1'b1, 1'b1);
    applyStimulus(addr(1, 1), 2'b00, 2'b00, 1'b0, 64'h0, 1'b0, 1'b1);
    checkOutput("rst_hit", s_hit, 0);
    checkOutput("rst_instr", s_instr, 0);
    checkOutput("rst_permit", s_permit, 1);

    // Permit table while everything misses
    for (int i = 0; i < 6; i++) begin
      applyStimulus(addr(1, 1), vt[i].src, vt[i].br, 1'b0, 64'h0, 1'b0, 1'b0);
      checkOutput("tbl_permit", s_permit, vt[i].exp_permit);
      checkOutput("tbl_hit", s_hit, 0);
    end

    // Fill every set and way, then read every word back
    for (int s = 0; s < S; s++)
      for (int w = 0; w < E; w++)
        fillLine(addr(((s * 8) + w) ^ 3, s), s * 4 + w, -1);
    for (int s = 0; s < S; s++)
      for (int w = 0; w < E; w++)
        readLine(addr(((s * 8) + w) ^ 3, s), s * 4 + w);

    // LRU: fill set 5, touch way 2, new tag replaces way 0
    applyStimulus(0, 2'b00, 2'b00, 1'b0, 64'h0, 1'b0, 1'b1);
    for (int w = 0; w < E; w++) fillLine(addr(100 + w, 5), 300 + w, -1);
    probe(addr(102, 5) | 32'h8);
    checkOutput("lru_touch_hit", s_hit, 1);
    checkOutput("lru_touch_word", s_instr, lw(302, 2));
    fillLine(addr(104, 5), 304, -1);
    probe(addr(100, 5));
    checkOutput("lru_evicted", s_hit, 0);
    readLine(addr(102, 5), 302);
    readLine(addr(104, 5), 304);
    readLine(addr(101, 5), 301);

    // Unresolved branch holds the refill back
    applyStimulus(0, 2'b00, 2'b00, 1'b0, 64'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(addr(7, 9), 2'b00, 2'b01, 1'b1, beat64(399, i), 1'b0, 1'b0);
      checkOutput("br_permit", s_permit, 0);
      checkOutput("br_hit", s_hit, 0);
    end
    probe(addr(7, 9));
    checkOutput("br_clear_permit", s_permit, 1);
    fillLine(addr(7, 9), 400, -1);
    readLine(addr(7, 9), 400);

    // 128-bit refill with three stalled cycles between beats 1 and 2
    applyStimulus(0, 2'b00, 2'b00, 1'b0, 64'h0, 1'b0, 1'b1);
    for (int c = 0; c < 7; c++) begin
      int k;
      ready128 = (c < 2 || c > 4);
      k = (c < 2) ? c : c - 3;
      rep128 = {lw(500, 4*k+3), lw(500, 4*k+2), lw(500, 4*k+1), lw(500, 4*k)};
      probe(addr(3, 2));
      if (c > 0) begin
        checkOutput("w128_fill_hit", s_hit128, 0);
        checkOutput("w128_fill_permit", s_permit128, 0);
      end
    end
    ready128 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      probe(addr(3, 2) | (32'(i) << 2));
      checkOutput("w128_hit", s_hit128, 1);
      checkOutput("w128_word", s_instr128, lw(500, i));
    end

    // Flush in the middle of a fill and on the last beat
    applyStimulus(0, 2'b00, 2'b00, 1'b0, 64'h0, 1'b0, 1'b1);
    fillLine(addr(11, 4), 600, -1);
    probe(addr(11, 4));
    checkOutput("pre_flush_hit", s_hit, 1);
    fillLine(addr(12, 4), 601, 5);
    probe(addr(11, 4));
    checkOutput("post_flush_hit", s_hit, 0);
    checkOutput("post_flush_permit", s_permit, 1);
    probe(addr(12, 4));
    checkOutput("aborted_line_hit", s_hit, 0);
    fillLine(addr(11, 4), 602, -1);
    readLine(addr(11, 4), 602);
    fillLine(addr(13, 4), 603, 7);
    probe(addr(13, 4));
    checkOutput("flush_last_beat_hit", s_hit, 0);

`ifdef ICACHE_PERF_CNT_EN
    // Counters: 4 fills, 10 hit cycles, then flush and reset
    applyStimulus(0, 2'b00, 2'b00, 1'b0, 64'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) fillLine(addr(20 + i, i), 700 + i, -1);
    for (int i = 0; i < 10; i++) probe(addr(20 + (i % 4), i % 4));
    applyStimulus(addr(30, 1), 2'b00, 2'b01, 1'b0, 64'h0, 1'b1, 1'b0);
    checkOutput("cnt_miss", s_mc, 4);
    checkOutput("cnt_hit", s_hc, 10);
    applyStimulus(addr(30, 1), 2'b00, 2'b01, 1'b0, 64'h0, 1'b0, 1'b1);
    checkOutput("cnt_miss_flush", s_mc, 4);
    checkOutput("cnt_hit_flush", s_hc, 10);
    probe(addr(30, 1));
    checkOutput("cnt_miss_rst", s_mc, 0);
    checkOutput("cnt_hit_rst", s_hc, 0);
`endif

    // Randomized traffic against the model
    applyStimulus(0, 2'b00, 2'b00, 1'b0, 64'h0, 1'b0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      a = (32'($urandom_range(0, 5)) << 11) | (32'($urandom_range(0, 3)) << 6) |
          (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      applyStimulus(a,
                    ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    ($urandom_range(0, 3) != 0),
                    {32'($urandom), 32'($urandom)},
                    ($urandom_range(0, 149) == 0),
                    ($urandom_range(0, 699) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
